// File: rtl/uart_pkg.sv
// Shared types for the UART echo buffer: transmit FSM states and pop-transform modes.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_IDLE = 2'd3
  } state_t;

  localparam int XFORM_PASS   = 0;
  localparam int XFORM_INVERT = 1;
  localparam int XFORM_UPPER  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count; the head entry is read combinationally.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_level;
  logic              w_pop;
  logic              w_push;

  assign full  = (r_level == (AW+1)'(DEPTH));
  assign empty = (r_level == '0);
  assign level = r_level;
  assign rdata = r_mem[r_rptr];

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/uart_echo_buffer.sv
// Buffers received UART characters and feeds them, optionally transformed, to a transmitter.
module uart_echo_buffer
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int XFORM  = 0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     rx_ready,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     hold,
  input  logic                     tx_busy,
  output logic                     tx_write,
  output logic [DATA_W-1:0]        tx_data,
  output logic [DATA_W-1:0]        last_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output state_t                   dbg_state
);

  state_t            r_state;
  state_t            w_next_state;
  logic              w_pop;
  logic              w_push_ok;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] r_tx_data;
  logic [DATA_W-1:0] r_last_data;
  logic              r_overflow;

  function automatic logic [DATA_W-1:0] f_xform(input logic [DATA_W-1:0] d);
    f_xform = d;
    if (XFORM == XFORM_INVERT) begin
      f_xform = ~d;
    end else if (XFORM == XFORM_UPPER) begin
      if (d >= DATA_W'(8'h61) && d <= DATA_W'(8'h7a)) f_xform = d - DATA_W'(8'h20);
    end
  endfunction

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (rx_ready),
    .pop    (w_pop),
    .wdata  (rx_data),
    .rdata  (w_head),
    .full   (w_full),
    .empty  (w_empty),
    .level  (level)
  );

  // Handshakes: rx_ready is a single-cycle strobe with no backpressure (a full FIFO
  // drops the character); tx_write is a single-cycle strobe, after which the
  // transmitter must raise tx_busy and later drop it before the next character.
  assign w_push_ok = rx_ready & (~w_full | w_pop);
  assign w_drop    = rx_ready & w_full & ~w_pop;

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !hold && !tx_busy) begin
          w_pop        = 1'b1;
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE:     w_next_state = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (tx_busy)  w_next_state = ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (!tx_busy) w_next_state = ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_tx_data   <= '0;
      r_last_data <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_pop)     r_tx_data   <= f_xform(w_head);
      if (w_push_ok) r_last_data <= rx_data;
      if (w_drop)    r_overflow  <= 1'b1;
    end
  end

  assign tx_write  = (r_state == ST_ISSUE);
  assign tx_data   = r_tx_data;
  assign last_data = r_last_data;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed bench for uart_echo_buffer: three instances (pass-through/16, uppercase/4, invert/4).
module tb_uart_echo_buffer;
  import uart_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [2:0]  rx_ready;
  logic [2:0]  hold;
  logic [2:0]  tx_busy = 3'b000;
  logic [2:0]  tx_write;
  logic [2:0]  overflow;
  logic [7:0]  rx_data   [3];
  logic [7:0]  tx_data   [3];
  logic [7:0]  last_data [3];
  state_t      st        [3];
  logic [4:0]  lvl0;
  logic [2:0]  lvl1;
  logic [2:0]  lvl2;

  uart_echo_buffer #(.DATA_W(8), .DEPTH(16), .XFORM(0)) u0 (
    .clk(clk), .resetn(resetn), .rx_ready(rx_ready[0]), .rx_data(rx_data[0]),
    .hold(hold[0]), .tx_busy(tx_busy[0]), .tx_write(tx_write[0]), .tx_data(tx_data[0]),
    .last_data(last_data[0]), .level(lvl0), .overflow(overflow[0]), .dbg_state(st[0]));

  uart_echo_buffer #(.DATA_W(8), .DEPTH(4), .XFORM(2)) u1 (
    .clk(clk), .resetn(resetn), .rx_ready(rx_ready[1]), .rx_data(rx_data[1]),
    .hold(hold[1]), .tx_busy(tx_busy[1]), .tx_write(tx_write[1]), .tx_data(tx_data[1]),
    .last_data(last_data[1]), .level(lvl1), .overflow(overflow[1]), .dbg_state(st[1]));

  uart_echo_buffer #(.DATA_W(8), .DEPTH(4), .XFORM(1)) u2 (
    .clk(clk), .resetn(resetn), .rx_ready(rx_ready[2]), .rx_data(rx_data[2]),
    .hold(hold[2]), .tx_busy(tx_busy[2]), .tx_write(tx_write[2]), .tx_data(tx_data[2]),
    .last_data(last_data[2]), .level(lvl2), .overflow(overflow[2]), .dbg_state(st[2]));

  // ---------------- transmitter model ----------------
  // mode 0: busy rises one negedge after the strobe is seen and lasts 10 cycles;
  // mode 1: busy stuck high; mode 2: busy stuck low.
  int busy_mode [3] = '{0, 0, 0};
  int busy_cnt  [3] = '{0, 0, 0};
  bit pend      [3] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (busy_mode[k] == 1) begin
        tx_busy[k] = 1'b1; busy_cnt[k] = 0; pend[k] = 0;
      end else if (busy_mode[k] == 2) begin
        tx_busy[k] = 1'b0; busy_cnt[k] = 0; pend[k] = 0;
      end else begin
        if (tx_write[k]) pend[k] = 1;
        else if (pend[k]) begin pend[k] = 0; busy_cnt[k] = 10; end
        tx_busy[k] = (busy_cnt[k] > 0);
        if (busy_cnt[k] > 0) busy_cnt[k] = busy_cnt[k] - 1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int         sel = 0;
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int         checks = 0;
  int         failures = 0;

  always @(negedge clk) begin
    if (tx_write[sel]) got_q.push_back(tx_data[sel]);
  end

  function automatic int get_level(input int k);
    case (k)
      0:       return int'(lvl0);
      1:       return int'(lvl1);
      default: return int'(lvl2);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_stream(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_char%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_seq(input int k, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      rx_ready[k] = 1'b1;
      rx_data[k]  = base + 8'(i);
      @(negedge clk);
    end
    rx_ready[k] = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int i = 0;
    while (got_q.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("strobe_wait", got_q.size() >= n, 1);
  endtask

  task automatic wait_idle(input int k);
    int i = 0;
    while (!(st[k] == ST_IDLE && tx_busy[k] == 1'b0 && get_level(k) == 0) && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("idle_wait", (st[k] == ST_IDLE && get_level(k) == 0), 1);
  endtask

  task automatic chk_zero(input int k, input string tag);
    chk({tag, "_tx_write"},  32'(tx_write[k]),  0);
    chk({tag, "_tx_data"},   32'(tx_data[k]),   0);
    chk({tag, "_last_data"}, 32'(last_data[k]), 0);
    chk({tag, "_level"},     get_level(k),      0);
    chk({tag, "_overflow"},  32'(overflow[k]),  0);
    chk({tag, "_state"},     32'(st[k]),        32'(ST_IDLE));
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int         inst;
    logic [7:0] rx;
    logic [7:0] tx;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{0, 8'h41, 8'h41};
    vecs[1] = '{0, 8'h5a, 8'h5a};
    vecs[2] = '{1, 8'h61, 8'h41};
    vecs[3] = '{1, 8'h5a, 8'h5a};
    vecs[4] = '{1, 8'h7b, 8'h7b};
    vecs[5] = '{1, 8'h7a, 8'h5a};
    vecs[6] = '{1, 8'h60, 8'h60};
    vecs[7] = '{2, 8'h0f, 8'hf0};
    vecs[8] = '{2, 8'ha5, 8'h5a};

    resetn   = 1'b0;
    rx_ready = '0;
    hold     = '0;
    for (int k = 0; k < 3; k++) rx_data[k] = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) chk_zero(k, $sformatf("reset%0d", k));
    resetn = 1'b1;
    @(negedge clk);

    // Single characters through each transform.
    for (int v = 0; v < 9; v++) begin
      sel = vecs[v].inst;
      got_q.delete();
      exp_q.delete();
      exp_q.push_back(vecs[v].tx);
      push_seq(vecs[v].inst, vecs[v].rx, 1);
      wait_strobes(1, 50);
      wait_idle(vecs[v].inst);
      compare_stream($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_last", v), 32'(last_data[vecs[v].inst]), 32'(vecs[v].rx));
    end

    // Burst while the transmitter is stuck busy, then release.
    sel = 0;
    busy_mode[0] = 1;
    repeat (2) @(negedge clk);
    got_q.delete();
    exp_q.delete();
    push_seq(0, 8'h01, 5);
    repeat (3) @(negedge clk);
    chk("burst_level", get_level(0), 5);
    chk("burst_no_strobe", got_q.size(), 0);
    busy_mode[0] = 0;
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    wait_strobes(5, 300);
    wait_idle(0);
    compare_stream("burst");

    // Overflow on a 4-deep instance while held.
    sel = 1;
    got_q.delete();
    exp_q.delete();
    hold[1] = 1'b1;
    push_seq(1, 8'h31, 6);
    chk("ovf_level", get_level(1), 4);
    chk("ovf_flag", 32'(overflow[1]), 1);
    chk("ovf_last", 32'(last_data[1]), 32'h34);
    chk("ovf_no_strobe", got_q.size(), 0);
    hold[1] = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h31 + 8'(i));
    wait_strobes(4, 300);
    wait_idle(1);
    compare_stream("ovf");
    chk("ovf_sticky", 32'(overflow[1]), 1);

    // Full FIFO: push lands on the same edge as the IDLE->ISSUE pop.
    sel = 2;
    got_q.delete();
    exp_q.delete();
    hold[2] = 1'b1;
    push_seq(2, 8'h10, 4);
    chk("fpp_full_level", get_level(2), 4);
    hold[2]     = 1'b0;
    rx_ready[2] = 1'b1;
    rx_data[2]  = 8'h14;
    @(negedge clk);
    rx_ready[2] = 1'b0;
    chk("fpp_level", get_level(2), 4);
    chk("fpp_overflow", 32'(overflow[2]), 0);
    chk("fpp_last", 32'(last_data[2]), 32'h14);
    chk("fpp_tx_write", 32'(tx_write[2]), 1);
    for (int i = 0; i < 5; i++) exp_q.push_back(~(8'h10 + 8'(i)));
    wait_strobes(5, 300);
    wait_idle(2);
    compare_stream("fpp");

    // Reset while waiting for busy with three entries queued.
    sel = 0;
    busy_mode[0] = 2;
    repeat (2) @(negedge clk);
    push_seq(0, 8'h61, 4);
    chk("rst_pre_state", 32'(st[0]), 32'(ST_WAIT_BUSY));
    chk("rst_pre_level", get_level(0), 3);
    resetn = 1'b0;
    @(negedge clk);
    chk_zero(0, "rst_mid");
    chk("rst_ovf_cleared", 32'(overflow[1]), 0);
    got_q.delete();
    resetn = 1'b1;
    busy_mode[0] = 0;
    repeat (20) @(negedge clk);
    chk("rst_no_strobe", got_q.size(), 0);
    chk("rst_post_level", get_level(0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_echo_buffer.md
UART_ECHO_BUFFER -- requirements
Module: uart_echo_buffer

Interface
REQ-001 Parameter DATA_W, default 8, width of one UART character.
REQ-002 Parameter DEPTH, default 16, FIFO entries; power of two, >= 2.
REQ-003 Parameter XFORM, default 0, transform applied on pop: 0 = pass-through, 1 = bitwise invert, 2 = ASCII lowercase-to-uppercase (only 'a'..'z' altered; DATA_W must be 8).
REQ-004 clk  in  1  single clock for all logic.
REQ-005 resetn  in  1  reset, synchronous to clk, active-low.
REQ-006 rx_ready  in  1  one-cycle strobe from the receiver: rx_data holds a new character.
REQ-007 rx_data  in  DATA_W  received character, valid when rx_ready=1.
REQ-008 hold  in  1  1 = stop draining the FIFO; receiving continues.
REQ-009 tx_busy  in  1  transmitter busy flag.
REQ-010 tx_write  out  1  one-cycle strobe to the transmitter.
REQ-011 tx_data  out  DATA_W  registered character for the transmitter; stable from the tx_write cycle until the next pop.
REQ-012 last_data  out  DATA_W  most recently accepted rx character, for the seven-segment display.
REQ-013 level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-014 overflow  out  1  sticky flag: a character was dropped.

Function
REQ-015 Push: rx_ready=1 and (level<DEPTH, or a pop occurs in the same cycle) -> rx_data is written; last_data <= rx_data on the next edge.
REQ-016 Drop: rx_ready=1, level=DEPTH and no pop that cycle -> character discarded, overflow <= 1, last_data unchanged.
REQ-017 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE.
REQ-018 IDLE -> ISSUE when level>0, hold=0 and tx_busy=0.
  - The pop occurs on this edge: tx_data <= XFORM(head), read pointer advances.
REQ-019 ISSUE: tx_write=1 for exactly one cycle; next state is WAIT_BUSY.
REQ-020 WAIT_BUSY: stay until tx_busy=1, then go to WAIT_IDLE.
REQ-021 WAIT_IDLE: stay until tx_busy=0, then go to IDLE.
  - Minimum spacing between tx_write strobes is therefore 4 cycles.
REQ-022 hold is sampled only in IDLE; asserting hold mid-transfer does not abort the transfer.
REQ-023 Simultaneous push and pop: level unchanged; full + push + pop both succeed.
REQ-024 Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-025 level is registered and updated on the same edge as the push/pop.
REQ-026 Characters are transmitted in receive order; none are duplicated.
REQ-027 tx_write is never asserted while level was 0 in the preceding IDLE cycle.

Reset
REQ-028 resetn=0 at a clk edge forces:
  - state=IDLE, tx_write=0, tx_data=0, last_data=0, level=0, overflow=0, pointers=0.
REQ-029 Reset mid-transfer abandons the transfer; FIFO contents are discarded; no strobe is issued in the cycle after release.
REQ-030 overflow clears only on reset.

Structure
REQ-031 Package uart_pkg holds the FSM state enum and the XFORM_* mode constants.
REQ-032 Storage and pointers go in sub-module sync_fifo (parameters DATA_W, DEPTH; push/pop/full/empty/level).
REQ-033 The FSM, the transform and the output registers are in uart_echo_buffer.

Verification
REQ-034 Single char: rx 0x41, tx_busy rises 2 cycles after tx_write and lasts 10 cycles -> one tx_write, tx_data=0x41, last_data=0x41, level returns to 0.
REQ-035 Burst: 5 chars 0x01..0x05 in consecutive cycles, tx_busy stuck high -> level=5, no strobe; release tx_busy -> 0x01..0x05 transmitted in order.
REQ-036 Overflow: DEPTH=4, hold=1, 6 chars -> level=4, overflow=1, last_data=4th char; hold=0 -> exactly chars 1..4 transmitted.
REQ-037 Full + push + pop: level=DEPTH, push coincides with the IDLE->ISSUE edge -> level stays DEPTH, overflow stays 0.
REQ-038 XFORM=2: rx 'a','Z','{' -> tx 'A','Z','{'; XFORM=1: rx 0x0F -> tx 0xF0.
REQ-039 Reset in WAIT_BUSY with 3 entries queued -> all outputs 0 next cycle, no tx_write after release.
